// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: fetch port, load/store port and RAM bus shared by the arbiter and its users.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
        output ram_en, ram_we, ram_addr, ram_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  if_gnt, if_rdata, if_valid, d_gnt, d_rdata, d_valid,
        input  ram_en, ram_we, ram_addr, ram_wdata, stall
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port synchronous RAM between instruction fetch and load/store,
// data-first with a starvation guard that forces a fetch after MAX_D contested data grants.
module ram_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int RAM_LAT = 1,
    parameter int MAX_D   = 3
) (
    input logic clk,
    input logic rst_n,
    ram_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_D + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_nx;
    logic [2:0]        cnt;
    logic [SW-1:0]     dstreak;
    logic              own_d, own_we;
    logic              grant, pick_if, pick_d;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    always_comb begin
        pick_if   = bus.if_req & (~bus.d_req | (dstreak == SW'(MAX_D)));
        pick_d    = bus.d_req & ~pick_if;
        grant     = (state == IDLE) & (bus.if_req | bus.d_req);
        addr_mux  = pick_d ? bus.d_addr : bus.if_addr;
        wdata_mux = pick_d ? bus.d_wdata : '0;
        state_nx  = grant ? WAIT : (state == WAIT && cnt == 3'd1) ? IDLE : state;
    end

    assign bus.if_gnt    = grant & pick_if;
    assign bus.d_gnt     = grant & pick_d;
    assign bus.ram_en    = grant;
    assign bus.ram_we    = grant & pick_d & bus.d_we;
    assign bus.ram_addr  = grant ? addr_mux : '0;
    assign bus.ram_wdata = grant ? wdata_mux : '0;
    assign bus.stall     = bus.if_req & ~bus.if_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            dstreak      <= '0;
            own_d        <= 1'b0;
            own_we       <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
        end else begin
            state        <= state_nx;
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            if (grant) begin
                cnt     <= 3'(RAM_LAT);
                own_d   <= pick_d;
                own_we  <= pick_d & bus.d_we;
                // a contested data win can never exceed MAX_D: at MAX_D the fetch wins instead
                dstreak <= (pick_d & bus.if_req) ? dstreak + 1'b1 : '0;
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) begin
                    if (own_d) begin
                        bus.d_valid <= 1'b1;
                        if (!own_we) bus.d_rdata <= bus.ram_rdata;
                    end else begin
                        bus.if_valid <= 1'b1;
                        bus.if_rdata <= bus.ram_rdata;
                    end
                end
            end
        end
    end
endmodule
